// File: rtl/res_station.sv
// Reservation station: addressed slots capture CDB operands and issue the
// lowest-index ready uop through a valid/ready issue register.
package res_station_pkg;
    localparam int unsigned RES_ST_AW       = 3;
    localparam int unsigned RES_ST_OP_WIDTH = 4;
    localparam int unsigned RES_ST_DW       = 32;

    typedef logic [RES_ST_AW-1:0]       res_st_addr_t;
    typedef logic [RES_ST_OP_WIDTH-1:0] res_st_op_t;

    typedef struct packed {
        logic                 busy;
        res_st_op_t           op;
        res_st_addr_t         qj;
        res_st_addr_t         qk;
        logic [RES_ST_DW-1:0] vj;
        logic [RES_ST_DW-1:0] vk;
        logic [RES_ST_DW-1:0] a;
    } res_st_cell_t;

    typedef struct packed {
        res_st_addr_t         tag;
        res_st_op_t           op;
        logic [RES_ST_DW-1:0] vj;
        logic [RES_ST_DW-1:0] vk;
        logic [RES_ST_DW-1:0] a;
    } res_st_issue_t;
endpackage

module res_station
    import res_station_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_in,
    input  logic                       wr_en_in,
    input  res_st_addr_t               wr_addr_in,
    input  res_st_cell_t               wr_data_in,
    output logic                       wr_err_out,
    input  logic                       cdb_valid_in,
    input  res_st_addr_t               cdb_tag_in,
    input  logic [RES_ST_DW-1:0]       cdb_data_in,
    input  logic                       issue_ready_in,
    output logic                       issue_valid_out,
    output res_st_addr_t               issue_tag_out,
    output logic [RES_ST_OP_WIDTH-1:0] issue_op_out,
    output logic [RES_ST_DW-1:0]       issue_vj_out,
    output logic [RES_ST_DW-1:0]       issue_vk_out,
    output logic [RES_ST_DW-1:0]       issue_a_out,
    output logic [RES_ST_AW:0]         free_count_out,
    output logic                       full_out
);
    localparam int unsigned AW    = $bits(res_st_addr_t);
    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CW    = AW + 1;

    res_st_cell_t  slots    [DEPTH];
    res_st_cell_t  slot_nxt [DEPTH];
    res_st_cell_t  wr_cell;
    res_st_issue_t iss_q, iss_d;
    logic          iss_valid_d;
    logic          wr_err_d;
    logic [DEPTH-1:0] rdy;
    res_st_addr_t  sel;
    logic          sel_valid;
    logic          issue_load;
    logic          cdb_hit;
    logic [CW-1:0] free_cnt;

    assign cdb_hit = cdb_valid_in && (cdb_tag_in != '0);

    // Ready vector and lowest-index select over slots 1..DEPTH-1 (pre-edge contents)
    always_comb begin
        rdy       = '0;
        sel       = '0;
        sel_valid = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            rdy[i] = slots[i].busy && (slots[i].qj == '0) && (slots[i].qk == '0);
        end
        for (int i = DEPTH - 1; i >= 1; i--) begin
            if (rdy[i]) begin
                sel_valid = 1'b1;
                sel       = AW'(i);
            end
        end
    end

    assign issue_load = sel_valid && (!issue_valid_out || issue_ready_in);

    // Incoming uop with same-cycle CDB bypass applied
    always_comb begin
        wr_cell      = wr_data_in;
        wr_cell.busy = 1'b1;
        if (cdb_hit && (wr_data_in.qj == cdb_tag_in)) begin
            wr_cell.vj = cdb_data_in;
            wr_cell.qj = '0;
        end
        if (cdb_hit && (wr_data_in.qk == cdb_tag_in)) begin
            wr_cell.vk = cdb_data_in;
            wr_cell.qk = '0;
        end
    end

    // Slot next state: flush > write > dequeue > wakeup
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_nxt[i] = slots[i];
            if (flush_in) begin
                slot_nxt[i].busy = 1'b0;
            end else begin
                if (slots[i].busy && cdb_hit && (slots[i].qj == cdb_tag_in)) begin
                    slot_nxt[i].vj = cdb_data_in;
                    slot_nxt[i].qj = '0;
                end
                if (slots[i].busy && cdb_hit && (slots[i].qk == cdb_tag_in)) begin
                    slot_nxt[i].vk = cdb_data_in;
                    slot_nxt[i].qk = '0;
                end
                if (issue_load && (sel == AW'(i))) begin
                    slot_nxt[i].busy = 1'b0;
                end
                if (wr_en_in && (i != 0) && (wr_addr_in == AW'(i))) begin
                    slot_nxt[i] = wr_cell;
                end
            end
        end
    end

    // Issue register and write-error next state
    always_comb begin
        iss_d       = iss_q;
        iss_valid_d = issue_valid_out;
        wr_err_d    = 1'b0;
        if (flush_in) begin
            iss_valid_d = 1'b0;
        end else begin
            wr_err_d = wr_en_in && ((wr_addr_in == '0) || slots[wr_addr_in].busy);
            if (issue_load) begin
                iss_valid_d = 1'b1;
                iss_d.tag   = sel;
                iss_d.op    = slots[sel].op;
                iss_d.vj    = slots[sel].vj;
                iss_d.vk    = slots[sel].vk;
                iss_d.a     = slots[sel].a;
            end else if (issue_ready_in) begin
                iss_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
            iss_q           <= '0;
            issue_valid_out <= 1'b0;
            wr_err_out      <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= slot_nxt[i];
            end
            iss_q           <= iss_d;
            issue_valid_out <= iss_valid_d;
            wr_err_out      <= wr_err_d;
        end
    end

    // Free slots among 1..DEPTH-1; slot 0 is the "operand ready" tag
    always_comb begin
        free_cnt = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (!slots[i].busy) begin
                free_cnt = free_cnt + CW'(1);
            end
        end
    end

    assign free_count_out = free_cnt;
    assign full_out       = (free_cnt == '0);
    assign issue_tag_out  = iss_q.tag;
    assign issue_op_out   = iss_q.op;
    assign issue_vj_out   = iss_q.vj;
    assign issue_vk_out   = iss_q.vk;
    assign issue_a_out    = iss_q.a;
endmodule

// File: tb/tb_res_station.sv
// Bench for res_station: vector table with issue scoreboard, plus directed
// sequences for stall, wakeup, full/error, flush and async reset.
module tb_res_station;
    import res_station_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush_in;
    logic                 wr_en_in;
    res_st_addr_t         wr_addr_in;
    res_st_cell_t         wr_data_in;
    logic                 wr_err_out;
    logic                 cdb_valid_in;
    res_st_addr_t         cdb_tag_in;
    logic [31:0]          cdb_data_in;
    logic                 issue_ready_in;
    logic                 issue_valid_out;
    res_st_addr_t         issue_tag_out;
    res_st_op_t           issue_op_out;
    logic [31:0]          issue_vj_out;
    logic [31:0]          issue_vk_out;
    logic [31:0]          issue_a_out;
    logic [RES_ST_AW:0]   free_count_out;
    logic                 full_out;

    res_station dut (
        .clk(clk), .rst(rst), .flush_in(flush_in),
        .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
        .wr_err_out(wr_err_out),
        .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
        .issue_ready_in(issue_ready_in), .issue_valid_out(issue_valid_out),
        .issue_tag_out(issue_tag_out), .issue_op_out(issue_op_out),
        .issue_vj_out(issue_vj_out), .issue_vk_out(issue_vk_out), .issue_a_out(issue_a_out),
        .free_count_out(free_count_out), .full_out(full_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic [3:0]  op;
        logic [2:0]  qj;
        logic [2:0]  qk;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] a;
        logic        cdb_v;
        logic [2:0]  cdb_tag;
        logic [31:0] cdb_data;
        logic [31:0] exp_vj;
        logic [31:0] exp_vk;
    } vec_t;

    typedef struct {
        logic [2:0]  tag;
        logic [3:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] a;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input logic [2:0] addr, input logic [3:0] op, input logic [2:0] qj,
                            input logic [2:0] qk, input logic [31:0] vj, input logic [31:0] vk,
                            input logic [31:0] a);
        wr_en_in   = 1'b1;
        wr_addr_in = addr;
        wr_data_in = '{busy: 1'b0, op: op, qj: qj, qk: qk, vj: vj, vk: vk, a: a};
    endtask

    function automatic exp_t mk_exp(input logic [2:0] tag, input logic [3:0] op,
                                    input logic [31:0] vj, input logic [31:0] vk,
                                    input logic [31:0] a);
        exp_t e;
        e.tag = tag; e.op = op; e.vj = vj; e.vk = vk; e.a = a;
        return e;
    endfunction

    // Scoreboard: every completed issue handshake must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && issue_valid_out && issue_ready_in) begin
            if (sb.size() == 0) begin
                check("unexpected_issue_tag", 32'(issue_tag_out), 32'hffff_ffff);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_tag", 32'(issue_tag_out), 32'(e.tag));
                check("sb_op",  32'(issue_op_out),  32'(e.op));
                check("sb_vj",  issue_vj_out, e.vj);
                check("sb_vk",  issue_vk_out, e.vk);
                check("sb_a",   issue_a_out,  e.a);
            end
        end
    end

    vec_t vecs[8];

    initial begin
        vecs[0] = '{3'd1, 4'd1, 3'd0, 3'd0, 32'd11,   32'd22,   32'h100, 1'b0, 3'd0, 32'd0,        32'd11,       32'd22};
        vecs[1] = '{3'd2, 4'd2, 3'd5, 3'd0, 32'd0,    32'd3,    32'h104, 1'b1, 3'd5, 32'h0000aaaa, 32'h0000aaaa, 32'd3};
        vecs[2] = '{3'd3, 4'd3, 3'd0, 3'd6, 32'd9,    32'd0,    32'h108, 1'b1, 3'd6, 32'h55,       32'd9,        32'h55};
        vecs[3] = '{3'd4, 4'd4, 3'd7, 3'd7, 32'd0,    32'd0,    32'h10c, 1'b1, 3'd7, 32'h1234,     32'h1234,     32'h1234};
        vecs[4] = '{3'd5, 4'd5, 3'd0, 3'd0, 32'd44,   32'd55,   32'h110, 1'b1, 3'd0, 32'hdead,     32'd44,       32'd55};
        vecs[5] = '{3'd6, 4'd6, 3'd0, 3'd0, 32'd66,   32'd77,   32'h114, 1'b0, 3'd0, 32'd0,        32'd66,       32'd77};
        vecs[6] = '{3'd7, 4'd7, 3'd2, 3'd0, 32'd0,    32'd88,   32'h118, 1'b1, 3'd2, 32'hbeef,     32'hbeef,     32'd88};
        vecs[7] = '{3'd1, 4'd8, 3'd0, 3'd0, 32'd99,   32'd100,  32'h11c, 1'b0, 3'd0, 32'd0,        32'd99,       32'd100};

        rst = 1'b1; flush_in = 1'b0; wr_en_in = 1'b0; wr_addr_in = '0; wr_data_in = '0;
        cdb_valid_in = 1'b0; cdb_tag_in = '0; cdb_data_in = '0; issue_ready_in = 1'b0;
        step(); step();

        check("rst_valid", 32'(issue_valid_out), 32'd0);
        check("rst_tag",   32'(issue_tag_out),   32'd0);
        check("rst_vj",    issue_vj_out,         32'd0);
        check("rst_err",   32'(wr_err_out),      32'd0);
        check("rst_free",  32'(free_count_out),  32'd7);
        check("rst_full",  32'(full_out),        32'd0);
        rst = 1'b0;
        step();

        // Latency: write at edge E, issue visible after E+1
        issue_ready_in = 1'b1;
        drive_wr(3'd3, 4'd1, 3'd0, 3'd0, 32'd5, 32'd7, 32'd0);
        sb.push_back(mk_exp(3'd3, 4'd1, 32'd5, 32'd7, 32'd0));
        step();
        wr_en_in = 1'b0;
        check("lat_valid_e", 32'(issue_valid_out), 32'd0);
        check("lat_free_e",  32'(free_count_out),  32'd6);
        step();
        check("lat_valid_e1", 32'(issue_valid_out), 32'd1);
        check("lat_tag_e1",   32'(issue_tag_out),   32'd3);
        check("lat_free_e1",  32'(free_count_out),  32'd7);
        step();
        check("lat_valid_e2", 32'(issue_valid_out), 32'd0);

        // CDB wakeup after a wait
        drive_wr(3'd2, 4'd2, 3'd5, 3'd0, 32'd0, 32'd1, 32'h20);
        step();
        wr_en_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wake_wait_valid", 32'(issue_valid_out), 32'd0);
        end
        cdb_valid_in = 1'b1; cdb_tag_in = 3'd5; cdb_data_in = 32'h10;
        sb.push_back(mk_exp(3'd2, 4'd2, 32'h10, 32'd1, 32'h20));
        step();
        cdb_valid_in = 1'b0; cdb_tag_in = '0; cdb_data_in = '0;
        check("wake_valid_c", 32'(issue_valid_out), 32'd0);
        step();
        check("wake_valid_c1", 32'(issue_valid_out), 32'd1);
        check("wake_tag_c1",   32'(issue_tag_out),   32'd2);
        check("wake_vj_c1",    issue_vj_out,         32'h10);
        step();

        // Table: one write per cycle with ready held high, including bypass cases
        for (int i = 0; i < 8; i++) begin
            drive_wr(vecs[i].addr, vecs[i].op, vecs[i].qj, vecs[i].qk, vecs[i].vj, vecs[i].vk, vecs[i].a);
            cdb_valid_in = vecs[i].cdb_v; cdb_tag_in = vecs[i].cdb_tag; cdb_data_in = vecs[i].cdb_data;
            sb.push_back(mk_exp(vecs[i].addr, vecs[i].op, vecs[i].exp_vj, vecs[i].exp_vk, vecs[i].a));
            step();
            check("tbl_wr_err", 32'(wr_err_out), 32'd0);
        end
        wr_en_in = 1'b0; cdb_valid_in = 1'b0; cdb_tag_in = '0; cdb_data_in = '0;
        for (int i = 0; i < 20 && (sb.size() != 0 || issue_valid_out); i++) step();
        check("tbl_drained", 32'(sb.size()), 32'd0);
        check("tbl_free",    32'(free_count_out), 32'd7);

        // Stall: 6 held, then lowest-index 1 before 4
        issue_ready_in = 1'b0;
        drive_wr(3'd6, 4'd6, 3'd0, 3'd0, 32'h60, 32'h61, 32'h62); step();
        drive_wr(3'd4, 4'd4, 3'd0, 3'd0, 32'h40, 32'h41, 32'h42); step();
        drive_wr(3'd1, 4'd1, 3'd0, 3'd0, 32'h10, 32'h11, 32'h12); step();
        wr_en_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_valid", 32'(issue_valid_out), 32'd1);
            check("stall_tag",   32'(issue_tag_out),   32'd6);
            check("stall_vj",    issue_vj_out,         32'h60);
        end
        check("stall_free", 32'(free_count_out), 32'd5);
        sb.push_back(mk_exp(3'd6, 4'd6, 32'h60, 32'h61, 32'h62));
        sb.push_back(mk_exp(3'd1, 4'd1, 32'h10, 32'h11, 32'h12));
        sb.push_back(mk_exp(3'd4, 4'd4, 32'h40, 32'h41, 32'h42));
        issue_ready_in = 1'b1;
        step(); step(); step();
        check("stall_after_valid", 32'(issue_valid_out), 32'd0);
        check("stall_sb_empty",    32'(sb.size()),       32'd0);

        // Fill, slot-0 write, busy overwrite
        issue_ready_in = 1'b0;
        for (int a = 1; a < 8; a++) begin
            drive_wr(3'(a), 4'd3, 3'd5, 3'd0, 32'd0, 32'(a), 32'd0);
            step();
        end
        wr_en_in = 1'b0;
        check("fill_full",  32'(full_out),       32'd1);
        check("fill_free",  32'(free_count_out), 32'd0);
        check("fill_err",   32'(wr_err_out),     32'd0);
        check("fill_valid", 32'(issue_valid_out), 32'd0);
        drive_wr(3'd0, 4'd1, 3'd0, 3'd0, 32'd1, 32'd1, 32'd1);
        step();
        wr_en_in = 1'b0;
        check("slot0_err",  32'(wr_err_out), 32'd1);
        check("slot0_full", 32'(full_out),   32'd1);
        step();
        check("slot0_err_clr", 32'(wr_err_out), 32'd0);
        drive_wr(3'd2, 4'd9, 3'd0, 3'd0, 32'h77, 32'h88, 32'h99);
        step();
        wr_en_in = 1'b0;
        check("ovw_err", 32'(wr_err_out), 32'd1);
        step();
        check("ovw_err_clr", 32'(wr_err_out),      32'd0);
        check("ovw_valid",   32'(issue_valid_out), 32'd1);
        check("ovw_tag",     32'(issue_tag_out),   32'd2);
        check("ovw_vj",      issue_vj_out,         32'h77);
        check("ovw_op",      32'(issue_op_out),    32'd9);
        check("ovw_free",    32'(free_count_out),  32'd1);

        // Flush with a simultaneous write
        flush_in = 1'b1;
        drive_wr(3'd2, 4'd1, 3'd0, 3'd0, 32'd1, 32'd2, 32'd3);
        step();
        flush_in = 1'b0; wr_en_in = 1'b0;
        check("flush_valid", 32'(issue_valid_out), 32'd0);
        check("flush_free",  32'(free_count_out),  32'd7);
        check("flush_err",   32'(wr_err_out),      32'd0);
        check("flush_full",  32'(full_out),        32'd0);
        step();
        check("flush_valid2", 32'(issue_valid_out), 32'd0);

        // Async reset mid-stall
        drive_wr(3'd1, 4'd5, 3'd0, 3'd0, 32'h5a, 32'h5b, 32'h5c);
        step();
        wr_en_in = 1'b0;
        step();
        check("pre_rst_valid", 32'(issue_valid_out), 32'd1);
        check("pre_rst_tag",   32'(issue_tag_out),   32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(issue_valid_out), 32'd0);
        check("arst_tag",   32'(issue_tag_out),   32'd0);
        check("arst_vj",    issue_vj_out,         32'd0);
        check("arst_free",  32'(free_count_out),  32'd7);
        step();
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
